// File: rtl/jtag_soc_mailbox_if.sv
// jtag_soc_mailbox_if: SoC-side RX/TX byte FIFO handshakes.
// slave = mailbox, master = SoC software side.
interface jtag_soc_mailbox_if;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;

  modport master (
    input  rx_data_o, rx_valid_o, tx_ready_o,
    output rx_ready_i, tx_data_i, tx_valid_i
  );

  modport slave (
    output rx_data_o, rx_valid_o, tx_ready_o,
    input  rx_ready_i, tx_data_i, tx_valid_i
  );
endinterface

// File: rtl/jtag_soc_mailbox.sv
// jtag_soc_mailbox: JTAG config-register mailbox with RX/TX byte FIFOs.
// Optional irq_o port and logic when JTAG_MBOX_IRQ_EN is defined.
module jtag_soc_mailbox #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] jtag_reg_i,
  output logic [7:0] jtag_reg_o,
`ifdef JTAG_MBOX_IRQ_EN
  output logic       irq_o,
`endif
  jtag_soc_mailbox_if.slave soc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [AW:0]   PONE = 1;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WR_LO = 3'd1;
  localparam logic [2:0] OP_WR_HI = 3'd2;
  localparam logic [2:0] OP_RD_LO = 3'd3;
  localparam logic [2:0] OP_RD_HI = 3'd4;
  localparam logic [2:0] OP_STAT  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_EXEC   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic       r_req;
  logic [2:0] r_op;
  logic [3:0] r_nib;
  logic [3:0] r_stash;
  logic [7:0] r_jreg;

  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [AW:0]   r_rx_wp;
  logic [AW:0]   r_rx_rp;
  logic [CW-1:0] r_rx_cnt;
  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [AW:0]   r_tx_wp;
  logic [AW:0]   r_tx_rp;
  logic [CW-1:0] r_tx_cnt;

  logic          w_pend;
  logic          w_latch;
  logic          w_exec;
  logic          w_err;
  logic [3:0]    w_data;
  logic          w_wr_lo;
  logic          w_rx_push;
  logic          w_rx_pop;
  logic          w_tx_push;
  logic          w_tx_pop;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic [7:0]    w_tx_head;
  logic [CW-1:0] w_rx_cnt_nx;
  logic [CW-1:0] w_tx_cnt_nx;

  assign w_pend     = r_sync2[7] != r_jreg[7];
  assign w_rx_full  = r_rx_cnt == FULL;
  assign w_rx_empty = r_rx_cnt == '0;
  assign w_tx_full  = r_tx_cnt == FULL;
  assign w_tx_empty = r_tx_cnt == '0;
  assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];

  assign w_rx_pop    = !w_rx_empty && soc.rx_ready_i;
  assign w_tx_push   = soc.tx_valid_i && !w_tx_full;
  assign w_rx_cnt_nx = r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
  assign w_tx_cnt_nx = r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);

  assign soc.rx_valid_o = !w_rx_empty;
  assign soc.rx_data_o  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[AW-1:0]];
  assign soc.tx_ready_o = !w_tx_full;
  assign jtag_reg_o     = r_jreg;

  // Two-flop synchronizer for the whole TCK-domain command word
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= jtag_reg_i;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  // FSM next state; SETTLE drops a request that vanished (glitch)
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:   if (w_pend) w_state_nx = S_SETTLE;
      S_SETTLE: w_state_nx = w_pend ? S_EXEC : S_IDLE;
      S_EXEC:   w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_latch = (r_state == S_SETTLE) && w_pend;
    w_exec  = (r_state == S_EXEC);
  end

  // Op decode, active only in EXEC
  always_comb begin
    w_err     = 1'b0;
    w_data    = '0;
    w_wr_lo   = 1'b0;
    w_rx_push = 1'b0;
    w_tx_pop  = 1'b0;
    if (w_exec) begin
      unique case (1'b1)
        (r_op == OP_NOP): begin
        end
        (r_op == OP_WR_LO): w_wr_lo = 1'b1;
        (r_op == OP_WR_HI): begin
          if (w_rx_full) w_err     = 1'b1;
          else           w_rx_push = 1'b1;
        end
        (r_op == OP_RD_LO): begin
          if (w_tx_empty) w_err  = 1'b1;
          else            w_data = w_tx_head[3:0];
        end
        (r_op == OP_RD_HI): begin
          if (w_tx_empty) begin
            w_err = 1'b1;
          end else begin
            w_data   = w_tx_head[7:4];
            w_tx_pop = 1'b1;
          end
        end
        (r_op == OP_STAT): w_data = 4'(r_tx_cnt);
        default: w_err = 1'b1;
      endcase
    end
  end

  // Latch the settled command and keep the low-nibble stash
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_req   <= 1'b0;
      r_op    <= '0;
      r_nib   <= '0;
      r_stash <= '0;
    end else begin
      if (w_latch) begin
        r_req <= r_sync2[7];
        r_op  <= r_sync2[6:4];
        r_nib <= r_sync2[3:0];
      end
      if (w_wr_lo) r_stash <= r_nib;
    end
  end

  // Response word, only rewritten in EXEC
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_jreg <= 8'h10;
    end else if (w_exec) begin
      r_jreg <= {r_req, w_err, w_rx_cnt_nx == FULL,
                 w_tx_cnt_nx == '0, w_data};
    end
  end

  // RX storage
  always_ff @(posedge clk_i) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= {r_nib, r_stash};
  end

  // RX pointers and count
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + PONE;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + PONE;
      r_rx_cnt <= w_rx_cnt_nx;
    end
  end

  // TX storage
  always_ff @(posedge clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= soc.tx_data_i;
  end

  // TX pointers and count
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + PONE;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PONE;
      r_tx_cnt <= w_tx_cnt_nx;
    end
  end

`ifdef JTAG_MBOX_IRQ_EN
  logic r_irq;

  // Pulse on RX empty->non-empty or TX full->not-full via RD_HI
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (w_rx_empty && w_rx_cnt_nx != '0) ||
               (w_tx_full && w_tx_pop && w_tx_cnt_nx != FULL);
    end
  end

  assign irq_o = r_irq;
`endif

endmodule

// File: tb/tb_jtag_soc_mailbox.sv
// tb_jtag_soc_mailbox: directed bench with a queue-based mailbox model.
// Model state is committed the moment the DUT acknowledges a request.
module tb_jtag_soc_mailbox;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] jtag_reg_i = 8'h00;
  logic [7:0] jtag_reg_o;
`ifdef JTAG_MBOX_IRQ_EN
  logic       irq_o;
`endif

  jtag_soc_mailbox_if soc();

  jtag_soc_mailbox #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .jtag_reg_i (jtag_reg_i),
    .jtag_reg_o (jtag_reg_o),
`ifdef JTAG_MBOX_IRQ_EN
    .irq_o      (irq_o),
`endif
    .soc        (soc)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  bit         chk_en = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [3:0] m_stash;
  logic       m_req;
  logic [7:0] m_jreg;
  logic [7:0] b;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("jreg", jtag_reg_o, m_jreg);
      check("rx_valid", 8'(soc.rx_valid_o), 8'(rxq.size() != 0));
      check("rx_data", soc.rx_data_o,
            (rxq.size() != 0) ? rxq[0] : 8'h00);
      check("tx_ready", 8'(soc.tx_ready_o), 8'(txq.size() < DEPTH));
    end
  end

  task automatic do_reset();
    chk_en = 1'b0;
    rst_ni = 1'b0;
    jtag_reg_i = 8'h00;
    soc.rx_ready_i = 1'b0;
    soc.tx_valid_i = 1'b0;
    soc.tx_data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    rxq.delete();
    txq.delete();
    m_stash = 4'h0;
    m_req = 1'b0;
    m_jreg = 8'h10;
    chk_en = 1'b1;
  endtask

  task automatic do_req(input logic [2:0] op, input logic [3:0] nib);
    logic       err;
    logic [3:0] data;
    bit         push;
    bit         pop;
    logic [7:0] pb;
    logic [7:0] exp;
    int         rxn;
    int         txn;
    int         k;
    err = 1'b0;
    data = 4'h0;
    push = 1'b0;
    pop = 1'b0;
    pb = 8'h00;
    m_req = ~m_req;
    @(posedge clk);
    #1 jtag_reg_i = {m_req, op, nib};
    rxn = rxq.size();
    txn = txq.size();
    case (op)
      3'd0, 3'd1: err = 1'b0;
      3'd2: begin
        if (rxn == DEPTH) err = 1'b1;
        else begin push = 1'b1; pb = {nib, m_stash}; end
      end
      3'd3: begin
        if (txn == 0) err = 1'b1;
        else data = txq[0][3:0];
      end
      3'd4: begin
        if (txn == 0) err = 1'b1;
        else begin data = txq[0][7:4]; pop = 1'b1; end
      end
      3'd5: data = 4'(txn);
      default: err = 1'b1;
    endcase
    if (push) rxn++;
    if (pop) txn--;
    exp = {m_req, err, rxn == DEPTH, txn == 0, data};
    k = 0;
    while (jtag_reg_o[7] !== m_req && k < 12) begin
      @(posedge clk);
      #1 k++;
    end
    check("ack_latency", 8'(k), 8'd5);
    if (op == 3'd1) m_stash = nib;
    if (push) rxq.push_back(pb);
    if (pop) void'(txq.pop_front());
    m_jreg = exp;
    check("resp", jtag_reg_o, exp);
  endtask

  task automatic tx_push(input logic [7:0] d);
    @(posedge clk);
    #1 soc.tx_data_i = d;
    soc.tx_valid_i = 1'b1;
    @(posedge clk);
    #1 soc.tx_valid_i = 1'b0;
    if (txq.size() < DEPTH) txq.push_back(d);
  endtask

  task automatic rx_pop(output logic [7:0] d);
    @(posedge clk);
    #1 d = soc.rx_data_o;
    soc.rx_ready_i = 1'b1;
    @(posedge clk);
    #1 soc.rx_ready_i = 1'b0;
    if (rxq.size() != 0) void'(rxq.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_jreg", jtag_reg_o, 8'h10);
    check("rst_rx_valid", 8'(soc.rx_valid_o), 8'h00);
    check("rst_rx_data", soc.rx_data_o, 8'h00);
    check("rst_tx_ready", 8'(soc.tx_ready_o), 8'h01);

    do_req(3'd1, 4'hA);
    check("wrlo_lit", jtag_reg_o, 8'h90);
    do_req(3'd2, 4'h5);
    check("wrhi_lit", jtag_reg_o, 8'h10);
    check("wrhi_rx_data", soc.rx_data_o, 8'h5A);
    rx_pop(b);
    check("pop_5a", b, 8'h5A);

    tx_push(8'hC3);
    do_req(3'd3, 4'h0);
    check("rdlo_lit", jtag_reg_o, 8'h83);
    do_req(3'd4, 4'h0);
    check("rdhi_lit", jtag_reg_o, 8'h1C);
    check("rdhi_tx_ready", 8'(soc.tx_ready_o), 8'h01);
    do_req(3'd4, 4'h0);
    check("underflow_lit", jtag_reg_o, 8'hD0);
    do_req(3'd0, 4'hF);
    check("nop_lit", jtag_reg_o, 8'h10);
    do_req(3'd6, 4'h1);
    check("rsv6_lit", jtag_reg_o, 8'hD0);
    do_req(3'd7, 4'h2);
    check("rsv7_lit", jtag_reg_o, 8'h50);

    tx_push(8'h11);
    tx_push(8'h22);
    tx_push(8'h33);
    do_req(3'd5, 4'h0);
    check("status3_lit", jtag_reg_o, 8'h83);
    tx_push(8'h44);
    tx_push(8'h55);
    check("tx_full_lit", 8'(soc.tx_ready_o), 8'h00);
    do_req(3'd5, 4'h0);
    check("status4_lit", jtag_reg_o, 8'h04);
    do_req(3'd3, 4'h0);
    check("rdlo_full_lit", jtag_reg_o, 8'h81);
    do_req(3'd4, 4'h0);
    check("rdhi_full_lit", jtag_reg_o, 8'h01);
    check("tx_unfull_lit", 8'(soc.tx_ready_o), 8'h01);
    do_req(3'd4, 4'h0);
    do_req(3'd4, 4'h0);
    do_req(3'd4, 4'h0);
    check("drain_lit", jtag_reg_o, 8'h94);

    do_req(3'd1, 4'h3);
    for (int i = 1; i <= DEPTH; i++) do_req(3'd2, 4'(i));
    check("rx_full_bit", 8'(jtag_reg_o[5]), 8'h01);
    do_req(3'd2, 4'h9);
    check("overflow_bits", 8'(jtag_reg_o[6:5]), 8'h03);
    for (int i = 1; i <= DEPTH; i++) begin
      rx_pop(b);
      check("ovf_pop", b, {4'(i), 4'h3});
    end
    check("ovf_empty", 8'(soc.rx_valid_o), 8'h00);

    @(posedge clk);
    #1 jtag_reg_i = {~m_req, 3'd2, 4'h7};
    @(posedge clk);
    #1 jtag_reg_i = {m_req, 3'd2, 4'h7};
    repeat (10) @(posedge clk);
    #1;
    check("glitch_jreg", jtag_reg_o, m_jreg);
    check("glitch_rx", 8'(soc.rx_valid_o), 8'h00);
    do_req(3'd0, 4'h0);

    do_req(3'd1, 4'h6);
    m_req = ~m_req;
    @(posedge clk);
    #1 jtag_reg_i = {m_req, 3'd2, 4'h2};
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    do_reset();
    check("abort_jreg", jtag_reg_o, 8'h10);
    check("abort_rx", 8'(soc.rx_valid_o), 8'h00);
    do_req(3'd2, 4'h3);
    check("abort_stash", soc.rx_data_o, 8'h30);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
